sfx_tone_sequencer: RTL

//  Parametrised sound-effect generator for the Pong audio path; successor to the single-tone square-wave DAC driver.

---
 rtl/pong_audio_pkg.sv | 29 ++
 rtl/sfx_tone_sequencer_i2s_tx.sv | 77 +++++++
 rtl/sfx_tone_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pong_audio_pkg.sv
// Shared definitions for the Pong audio path: FSM encoding, default tone tables
// and an elaboration-time log2 helper.
package pong_audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int CLK_HZ = 50_000_000;

    // Index i lives at [32*i +: 32]; higher index = higher priority.
    localparam logic [95:0] TONE_HZ_DEFAULT = {32'd2000, 32'd1000, 32'd500};
    localparam logic [95:0] DUR_MS_DEFAULT  = {32'd400, 32'd60, 32'd30};

    // Ceiling log2, never below 1 so it is always usable as a vector width.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sfx_tone_sequencer_i2s_tx.sv
// I2S serialiser: one word latched per frame at the lrck 1->0 edge and sent on
// both channels, MSB one bclk after each lrck edge, outputs change on bclk fall.
module i2s_tx
    import pong_audio_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int BCLK_DIV = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                bclk,
    output logic                lrck,
    output logic                data
);
    localparam int DIV_W = clog2(BCLK_DIV);
    localparam int BIT_W = clog2(2 * SAMPLE_W);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(2 * SAMPLE_W - 1);
    localparam logic [BIT_W-1:0] SLOT_HALF = BIT_W'(SAMPLE_W);

    logic [DIV_W-1:0]    r_div;
    logic                r_bclk;
    logic                r_lrck;
    logic                r_data;
    logic [BIT_W-1:0]    r_slot;
    logic [SAMPLE_W-1:0] r_word;

    logic                w_div_wrap;
    logic                w_fall;
    logic                w_right;
    logic [BIT_W-1:0]    w_slot_next;
    logic [BIT_W-1:0]    w_pos;
    logic [BIT_W-1:0]    w_idx;
    logic [SAMPLE_W-1:0] w_shifted;

    // Slot 0 of each word carries the LSB of the previous word, so bit index
    // for position p>0 is SAMPLE_W-p and position 0 maps to bit 0.
    always_comb begin
        w_div_wrap  = (r_div == DIV_LAST);
        w_fall      = w_div_wrap && r_bclk;
        w_slot_next = (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
        w_right     = (w_slot_next >= SLOT_HALF);
        w_pos       = w_right ? (w_slot_next - SLOT_HALF) : w_slot_next;
        w_idx       = (w_pos == '0) ? '0 : (SLOT_HALF - w_pos);
        w_shifted   = r_word >> w_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
            r_lrck <= 1'b0;
            r_data <= 1'b0;
            r_slot <= SLOT_LAST;
            r_word <= '0;
        end else begin
            r_div <= w_div_wrap ? '0 : r_div + 1'b1;
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end
            if (w_fall) begin
                r_slot <= w_slot_next;
                r_lrck <= w_right;
                r_data <= w_shifted[0];
                if (w_slot_next == '0) begin
                    r_word <= sample;
                end
            end
        end
    end

    assign bclk = r_bclk;
    assign lrck = r_lrck;
    assign data = r_data;

endmodule

// File: rtl/sfx_tone_sequencer.sv
// Priority-arbitrated square-wave effect player: PLAY for DUR_MS, half-amplitude
// RELEASE for REL_MS, PCM streamed out over I2S.
module sfx_tone_sequencer #(
    parameter int                       CLK_HZ    = pong_audio_pkg::CLK_HZ,
    parameter int                       N_TONES   = 3,
    parameter logic [32*N_TONES-1:0]    TONE_HZ   = pong_audio_pkg::TONE_HZ_DEFAULT,
    parameter logic [32*N_TONES-1:0]    DUR_MS    = pong_audio_pkg::DUR_MS_DEFAULT,
    parameter int                       REL_MS    = 8,
    parameter int                       TICK_CYC  = CLK_HZ / 1000,
    parameter int                       SAMPLE_W  = 16,
    parameter logic signed [SAMPLE_W-1:0] AMPLITUDE = 16'sh2000,
    parameter int                       BCLK_DIV  = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_TONES-1:0]                        tone_req,
    output logic                                      busy,
    output logic [pong_audio_pkg::clog2(N_TONES)-1:0] active_tone,
    output logic                                      dac_bclk,
    output logic                                      dac_lrck,
    output logic                                      dac_data
);
    import pong_audio_pkg::*;

    localparam int ACT_W  = clog2(N_TONES);
    localparam int TICK_W = clog2(TICK_CYC);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    localparam logic signed [SAMPLE_W-1:0] AMP_PLAY_P = AMPLITUDE;
    localparam logic signed [SAMPLE_W-1:0] AMP_PLAY_N = -AMPLITUDE;
    localparam logic signed [SAMPLE_W-1:0] AMP_REL_P  = AMPLITUDE >>> 1;
    localparam logic signed [SAMPLE_W-1:0] AMP_REL_N  = -(AMPLITUDE >>> 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [N_TONES-1:0]    r_req_q;
    logic [N_TONES-1:0]    w_req_edge;
    logic [ACT_W-1:0]      r_active;
    logic [ACT_W-1:0]      w_win;
    logic                  w_any;
    logic                  w_accept;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic                  w_tick;
    logic [31:0]           r_ms_cnt;
    logic                  w_ms_last;
    logic [31:0]           r_half;
    logic [31:0]           r_phase;
    logic                  w_phase_wrap;
    logic                  r_pol;
    logic signed [SAMPLE_W-1:0] w_sample;
    logic [31:0]           w_half_tbl [N_TONES];
    logic [31:0]           w_dur_tbl  [N_TONES];

    for (genvar gi = 0; gi < N_TONES; gi++) begin : g_tone_tbl
        assign w_half_tbl[gi] = 32'(CLK_HZ / (2 * TONE_HZ[32*gi +: 32]));
        assign w_dur_tbl[gi]  = DUR_MS[32*gi +: 32];
    end

    assign w_req_edge = tone_req & ~r_req_q;

    // Ascending scan: the last set bit seen is the highest-priority request.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = 0; i < N_TONES; i++) begin
            if (w_req_edge[i]) begin
                w_win = ACT_W'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_accept     = w_any && ((r_state != ST_PLAY) || (w_win >= r_active));
    assign w_tick       = (r_tick_cnt == TICK_LAST);
    assign w_ms_last    = (r_ms_cnt == 32'd1);
    assign w_phase_wrap = (r_phase == r_half - 32'd1);

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = ST_PLAY;
        end else if (w_tick && w_ms_last) begin
            case (r_state)
                ST_PLAY:    w_state_next = (REL_MS > 0) ? ST_RELEASE : ST_IDLE;
                ST_RELEASE: w_state_next = ST_IDLE;
                default:    w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Accept takes precedence over a coincident ms tick or phase wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q    <= '0;
            r_active   <= '0;
            r_tick_cnt <= '0;
            r_ms_cnt   <= '0;
            r_half     <= 32'd1;
            r_phase    <= '0;
            r_pol      <= 1'b1;
        end else begin
            r_req_q <= tone_req;
            if (w_accept) begin
                r_active   <= w_win;
                r_tick_cnt <= '0;
                r_ms_cnt   <= w_dur_tbl[w_win];
                r_half     <= w_half_tbl[w_win];
                r_phase    <= '0;
                r_pol      <= 1'b1;
            end else begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                if (w_tick && (r_state != ST_IDLE)) begin
                    r_ms_cnt <= (w_ms_last && (r_state == ST_PLAY)) ? 32'(REL_MS)
                                                                    : r_ms_cnt - 32'd1;
                end
                if (r_state != ST_IDLE) begin
                    r_phase <= w_phase_wrap ? '0 : r_phase + 32'd1;
                    if (w_phase_wrap) begin
                        r_pol <= ~r_pol;
                    end
                end
                if (w_state_next == ST_IDLE) begin
                    r_active <= '0;
                end
            end
        end
    end

    always_comb begin
        w_sample = '0;
        case (r_state)
            ST_PLAY:    w_sample = r_pol ? AMP_PLAY_P : AMP_PLAY_N;
            ST_RELEASE: w_sample = r_pol ? AMP_REL_P : AMP_REL_N;
            default:    w_sample = '0;
        endcase
    end

    i2s_tx #(
        .SAMPLE_W (SAMPLE_W),
        .BCLK_DIV (BCLK_DIV)
    ) u_i2s_tx (
        .clk    (clk),
        .rst    (rst),
        .sample (w_sample),
        .bclk   (dac_bclk),
        .lrck   (dac_lrck),
        .data   (dac_data)
    );

    assign busy        = (r_state != ST_IDLE);
    assign active_tone = r_active;

endmodule
